// File: rtl/bullet_hit_detector_if.sv
// Bullet/enemy bus between the bullet FSM side and the hit detector.
// Carries the frame strobe, bullet/enemy geometry and the detector status outputs.
interface bullet_hit_detector_if;
    logic        frame_clk;
    logic        bullet;
    logic [9:0]  bullet_x;
    logic [9:0]  bullet_y;
    logic [9:0]  enemy_x;
    logic [9:0]  enemy_y;
    logic        collision;
    logic        hit_pulse;
    logic        enemy_visible;
    logic [2:0]  enemy_hp;
    logic [15:0] score;

    modport master (
        output frame_clk, bullet, bullet_x, bullet_y, enemy_x, enemy_y,
        input  collision, hit_pulse, enemy_visible, enemy_hp, score
    );

    modport slave (
        input  frame_clk, bullet, bullet_x, bullet_y, enemy_x, enemy_y,
        output collision, hit_pulse, enemy_visible, enemy_hp, score
    );
endinterface

// File: rtl/bullet_hit_detector.sv
// Bullet-vs-enemy hit detection with enemy hit-flash/death/respawn sequencing and kill score.
// Optional macro BULLET_HIT_LED_EN adds LEDR1, a debug LED toggling on every registered hit.
module bullet_hit_detector #(
    parameter logic [9:0]  ENEMY_W        = 10'd40,
    parameter logic [9:0]  ENEMY_H        = 10'd40,
    parameter logic [9:0]  BULLET_W       = 10'd10,
    parameter logic [9:0]  BULLET_H       = 10'd6,
    parameter int unsigned MAX_HP         = 3,
    parameter int unsigned FLASH_FRAMES   = 8,
    parameter int unsigned RESPAWN_FRAMES = 60
) (
    input  logic                 Clk,
    input  logic                 RESET_N,
    bullet_hit_detector_if.slave bus
`ifdef BULLET_HIT_LED_EN
    ,
    output logic                 LEDR1
`endif
);
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned HP_W    = 3;
    localparam int unsigned SCORE_W = 16;

    localparam logic [CNT_W-1:0]   FLASH_LAST   = CNT_W'(FLASH_FRAMES - 1);
    localparam logic [CNT_W-1:0]   RESPAWN_LAST = CNT_W'(RESPAWN_FRAMES - 1);
    localparam logic [HP_W-1:0]    HP_INIT      = HP_W'(MAX_HP);
    localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        HIT_FLASH = 2'd1,
        DEAD      = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [HP_W-1:0]      hp_q, hp_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 coll_q, coll_d;
    logic                 pulse_q, pulse_d;
    logic                 vis_q, vis_d;
    logic                 fc1_q, fc2_q;

    logic                 tick_c;
    logic                 overlap_c;
    logic                 hit_c;

    assign tick_c = fc1_q & ~fc2_q;

    // Sums are widened to 11 bits so boxes near the right/bottom edge never wrap.
    assign overlap_c = ({1'b0, bus.bullet_x} < ({1'b0, bus.enemy_x} + {1'b0, ENEMY_W}))
                    && (({1'b0, bus.bullet_x} + {1'b0, BULLET_W}) > {1'b0, bus.enemy_x})
                    && ({1'b0, bus.bullet_y} < ({1'b0, bus.enemy_y} + {1'b0, ENEMY_H}))
                    && (({1'b0, bus.bullet_y} + {1'b0, BULLET_H}) > {1'b0, bus.enemy_y});

    assign hit_c = tick_c & bus.bullet & overlap_c & (state_q == ALIVE) & ~coll_q;

    always_ff @(posedge Clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ALIVE;
            cnt_q   <= '0;
            hp_q    <= HP_INIT;
            score_q <= '0;
            coll_q  <= 1'b0;
            pulse_q <= 1'b0;
            vis_q   <= 1'b1;
            fc1_q   <= 1'b0;
            fc2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            score_q <= score_d;
            coll_q  <= coll_d;
            pulse_q <= pulse_d;
            vis_q   <= vis_d;
            fc1_q   <= bus.frame_clk;
            fc2_q   <= fc1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hp_d    = hp_q;
        score_d = score_q;
        coll_d  = coll_q;
        pulse_d = hit_c;
        vis_d   = vis_q;

        // Collision holds until the bullet FSM drops the bullet.
        if (hit_c) begin
            coll_d = 1'b1;
        end else if (!bus.bullet) begin
            coll_d = 1'b0;
        end

        unique case (state_q)
            ALIVE: begin
                if (hit_c) begin
                    cnt_d = '0;
                    if (hp_q > HP_W'(1)) begin
                        hp_d    = hp_q - HP_W'(1);
                        state_d = HIT_FLASH;
                    end else begin
                        hp_d    = '0;
                        state_d = DEAD;
                        if (score_q != SCORE_MAX) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                    end
                end
            end
            HIT_FLASH: begin
                if (tick_c) begin
                    if (cnt_q == FLASH_LAST) begin
                        state_d = ALIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DEAD: begin
                if (tick_c) begin
                    if (cnt_q == RESPAWN_LAST) begin
                        state_d = ALIVE;
                        cnt_d   = '0;
                        hp_d    = HP_INIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ALIVE;
                cnt_d   = '0;
            end
        endcase

        // Visibility follows the next state so it lines up with the registered state.
        unique case (state_d)
            ALIVE:     vis_d = 1'b1;
            HIT_FLASH: vis_d = ~cnt_d[1];
            default:   vis_d = 1'b0;
        endcase
    end

    assign bus.collision     = coll_q;
    assign bus.hit_pulse     = pulse_q;
    assign bus.enemy_visible = vis_q;
    assign bus.enemy_hp      = hp_q;
    assign bus.score         = score_q;

`ifdef BULLET_HIT_LED_EN
    logic led_q;

    always_ff @(posedge Clk or negedge RESET_N) begin
        if (!RESET_N) begin
            led_q <= 1'b0;
        end else begin
            led_q <= led_q ^ pulse_q;
        end
    end

    assign LEDR1 = led_q;
`endif

endmodule

// File: doc/bullet_hit_detector.md
Name: bullet_hit_detector

Overview:
Receiving end of the bullet interface. Each frame it tests the player bullet's box against one enemy's hit box. On a hit it returns the `collision` handshake to the bullet FSM and decrements enemy health. It also sequences the enemy through hit-flash, death and respawn, and keeps a kill score for the HUD/VGA layer.

Parameters:
- ENEMY_W, 10'd40, enemy hit-box width in pixels
- ENEMY_H, 10'd40, enemy hit-box height in pixels
- BULLET_W, 10'd10, bullet box width (matches bullet sprite)
- BULLET_H, 10'd6, bullet box height
- MAX_HP, 3, enemy health on spawn/respawn (1..7)
- FLASH_FRAMES, 8, invulnerable flash duration in frames
- RESPAWN_FRAMES, 60, dead time before respawn in frames

Ports:
- Clk  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- frame_clk  in  1  VGA frame strobe; rising edge detected internally with a 2-flop delay
- bullet  in  1  bullet in flight (from bullet FSM)
- bullet_x  in  10  bullet left edge
- bullet_y  in  10  bullet top edge
- enemy_x  in  10  enemy left edge
- enemy_y  in  10  enemy top edge
- collision  out  1  hit acknowledge to bullet FSM, held as a level
- hit_pulse  out  1  one-Clk pulse per registered hit
- enemy_visible  out  1  draw enable for enemy sprite
- enemy_hp  out  3  current health
- score  out  16  kill count, saturating

Behaviour:
- Reset (async, RESET_N=0) values:
  - state=ALIVE, enemy_hp=MAX_HP, collision=0, hit_pulse=0, score=0.
  - enemy_visible=1, frame counter=0, edge-detect flops=0.
- Frame tick: `tick` is one Clk wide, one cycle after the frame_clk rising edge. All game updates occur only on tick, except the collision clear.
- Overlap test: evaluated with 11-bit zero-extended sums so nothing wraps at x/y near 1023. A hit requires all four of:
  - bullet_x < enemy_x+ENEMY_W
  - bullet_x+BULLET_W > enemy_x
  - bullet_y < enemy_y+ENEMY_H
  - bullet_y+BULLET_H > enemy_y
- Hit accepted on tick only when ALL hold (registered values):
  - bullet=1
  - overlap
  - state==ALIVE
  - collision==0
- On an accepted hit, next cycle:
  - collision=1 and hit_pulse=1 (hit_pulse lasts one cycle).
  - enemy_hp decrements by 1.
- Collision handshake:
  - collision stays 1 until bullet is sampled 0 on any Clk; it clears on the following cycle.
  - While collision=1 no further hits are accepted (no double count from one bullet).
- States:
  - ALIVE: enemy_visible=1. Accepted hit with enemy_hp>1 → HIT_FLASH, frame counter=0. Accepted hit with enemy_hp==1 → DEAD, enemy_hp=0, score+1 (saturates at 16'hFFFF), frame counter=0.
  - HIT_FLASH: invulnerable; an overlapping bullet passes through with no collision. enemy_visible = ~counter[1] (blinks every 2 frames). Counter increments per tick; on the tick where counter==FLASH_FRAMES-1 → ALIVE.
  - DEAD: enemy_visible=0, no hits. On the tick where counter==RESPAWN_FRAMES-1 → ALIVE with enemy_hp=MAX_HP.
- Transition tick: state is registered, so on the tick a state returns to ALIVE no hit is evaluated. The first possible hit is the next tick.
- Simultaneous: if bullet falls on the same cycle as a tick, the bullet=0 sample wins and no hit is taken.
- Reset mid-operation: everything returns to reset values immediately, including a pending collision.
- Counter: 8 bits wide; FLASH_FRAMES and RESPAWN_FRAMES must be ≤255.

Optional Feature:
- Macro: BULLET_HIT_LED_EN.
- When defined: adds output port LEDR1 (1 bit, reset 0), which toggles on every hit_pulse for board-level debug.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
1. Reset then bullet=1, bullet_x=100, bullet_y=50, enemy_x=105, enemy_y=40, one tick → collision=1 and hit_pulse=1 one cycle later, enemy_hp=2. Drop bullet → collision=0 next cycle.
2. Overlap held for 3 ticks with bullet never dropped → exactly one hit; enemy_hp stays 2 and collision stays 1.
3. Second hit during HIT_FLASH (enemy_hp=2) → no collision. enemy_visible blinks with period 4 frames. ALIVE after 8 ticks; next hit gives enemy_hp=1.
4. Third hit → DEAD: enemy_hp=0, score=1, enemy_visible=0 for 60 ticks. Then ALIVE with enemy_hp=3. An overlapping bullet on the respawn tick is ignored and hits on the following tick.
5. Edge geometry: bullet_x=enemy_x+ENEMY_W (touching) → no hit. bullet_x=enemy_x+ENEMY_W-1 → hit. enemy_x=1000, bullet_x=1015 → hit with no wrap.
6. RESET_N pulsed low mid-HIT_FLASH with collision=1 → collision=0, enemy_hp=3, score=0 immediately, without waiting for a Clk edge.
